fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX/MEM + MEM/WB forwarding logic: one block does operand forwarding and load-use hazard detection.
- Keeps a shadow copy of destination info (rd, regwrite, memread) for EX and for NSTG forwarding stages after EX.
- Forward selects are produced for NSRC operands of the instruction in EX; a stall is produced for the instruction in ID.
- Sits beside the ID/EX pipeline registers of the 32-bit pipelined core.

Parameters:
- RW, 5, register address width.
- NSRC, 2, source operands per instruction.
- NSTG, 2, forwarding stages after EX (stage 0 = EX/MEM, youngest; stage NSTG-1 oldest).
- LOAD_STG, 1, first stage index at which load data can be forwarded; legal range 1..NSTG.
- CW, 16, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NSRC*RW  ID source register addresses; source s in bits [s*RW +: RW].
- id_src_used  in  NSRC  per-source "operand is read" flag.
- id_rd  in  RW  ID destination register.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  squash the instruction leaving ID this cycle.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  hold PC and IF/ID, and insert a bubble into EX.
- fwd_sel  out  NSRC*NSTG  per-source one-hot forward select for the EX operands.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- State: one EX entry plus P[0..NSTG-1].
  - EX entry: {valid, regwrite, memread, rd, src[NSRC], src_used[NSRC]}.
  - P[k]: {valid, regwrite, memread, rd}.
- An entry "produces r" when valid && regwrite && rd==r && r!=0. Register 0 never matches and is never forwarded.
- Reset (asynchronous, rst_n low): all valid bits 0, stall_cnt 0. Outputs then read stall=0, fwd_sel all 0. Reset mid-stall drops the stall immediately, with no deferred effect.
- Each rising edge, in order:
  - P[0] takes the EX entry; P[k] takes P[k-1] for k>=1. The stages after EX never stall.
  - If flush, or stall, or !id_valid: EX valid becomes 0 (bubble).
  - Otherwise EX loads the ID fields.
  - flush and stall together: result is a bubble; flush wins and no hazard is recorded.
- stall (combinational, registered state only, no internal loop):
  - For each ID source s with id_valid && id_src_used[s], find the youngest producer of id_src[s], searching EX first, then P[0], P[1], and so on.
  - stall=1 if that youngest producer is a load at EX, or a load at P[k] with k+1 < LOAD_STG.
  - Older matches behind a younger non-load producer never cause a stall.
- fwd_sel (combinational, from the EX entry and P):
  - For EX source s with EX valid && src_used[s], find the youngest P[k] producing src[s].
  - If found, set bit (NSTG-1-k) of source s's field; all other bits are 0.
  - No producer means all zero (register-file value).
  - With NSTG=2, 2'b10 = EX/MEM and 2'b01 = MEM/WB, so the legacy mux encoding is unchanged.
  - Youngest wins: EX/MEM and MEM/WB both matching gives 2'b10.
  - A match on a load at P[k] with k < LOAD_STG cannot occur, because the stall prevents it. The bench must assert this.
- stall_cnt:
  - cnt_clr has priority and sets the counter to 0.
  - Otherwise it increments when stall=1 and saturates at all-ones.
- Latency:
  - stall and fwd_sel: 0 cycles, combinational from state and ID inputs.
  - A dependent instruction issued right after a load sees exactly LOAD_STG stall cycles, then forwards from stage LOAD_STG.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> stall=0, fwd_sel=0, stall_cnt=0. Assert rst_n=0 asynchronously while stall=1 -> stall drops in the same cycle.
- Back-to-back ALU ops, with add r3,r1,r2 then sub r4,r3,r5 (NSTG=2) -> while sub is in EX, fwd_sel src0=2'b10, src1=2'b00; one cycle later an instruction reading r3 gets 2'b01; r0 as a destination never forwards.
- Double hazard: r3 written by instructions i and i+1, then read by i+2 -> 2'b10 (youngest wins), never 2'b01.
- Load-use, with lw r2 then add r5,r2,r2 and LOAD_STG=1 -> stall=1 for exactly 1 cycle, EX bubble, then add in EX with both sources 2'b01, stall_cnt=1. With LOAD_STG=2, NSTG=3 -> 2 stall cycles, then forward from stage 2.
- Flush while stall=1, and flush of an ALU op writing r7 -> EX bubble, and a later reader of r7 gets fwd_sel=0.
- Counter: force 2^CW+3 stall cycles -> stall_cnt holds all-ones. cnt_clr together with stall -> 0 on the next cycle.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// ID-stage request and hazard/forward response bundle for fwd_hazard_unit.
// master = pipeline control (drives ID fields), slave = the hazard unit.
interface fwd_hazard_if #(
  parameter int RW   = 5,
  parameter int NSRC = 2,
  parameter int NSTG = 2,
  parameter int CW   = 16
);
  logic                 id_valid;
  logic [NSRC*RW-1:0]   id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [RW-1:0]        id_rd;
  logic                 id_regwrite;
  logic                 id_memread;
  logic                 flush;
  logic                 cnt_clr;
  logic                 stall;
  logic [NSRC*NSTG-1:0] fwd_sel;
  logic [CW-1:0]        stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush, cnt_clr,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush, cnt_clr,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection using shadow copies of the
// EX entry and NSTG post-EX destination stages.
module fwd_hazard_unit #(
  parameter int RW       = 5,
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int LOAD_STG = 1,
  parameter int CW       = 16
) (
  input logic          clk,
  input logic          rst_n,
  fwd_hazard_if.slave  hz
);

  logic               ex_valid_q;
  logic               ex_rw_q;
  logic               ex_mr_q;
  logic [RW-1:0]      ex_rd_q;
  logic [NSRC*RW-1:0] ex_src_q;
  logic [NSRC-1:0]    ex_used_q;

  logic [NSTG-1:0]    p_valid_q;
  logic [NSTG-1:0]    p_rw_q;
  logic [NSTG-1:0]    p_mr_q;
  logic [RW-1:0]      p_rd_q [NSTG];

  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;

  logic               stall_s;
  logic               st_act_s;
  logic               st_hit_s;
  logic               st_found_s;
  logic [RW-1:0]      st_src_s;

  logic [NSRC*NSTG-1:0] fwd_s;
  logic               fw_act_s;
  logic               fw_hit_s;
  logic               fw_found_s;
  logic [RW-1:0]      fw_src_s;

  // Load-use stall: youngest producer of each ID source, EX searched first
  always_comb begin
    stall_s    = 1'b0;
    st_act_s   = 1'b0;
    st_hit_s   = 1'b0;
    st_found_s = 1'b0;
    st_src_s   = '0;
    for (int s = 0; s < NSRC; s++) begin
      st_src_s   = hz.id_src[s*RW +: RW];
      st_act_s   = hz.id_valid & hz.id_src_used[s] & (st_src_s != '0);
      st_hit_s   = ex_valid_q & ex_rw_q & (ex_rd_q == st_src_s);
      stall_s    = stall_s | (st_act_s & st_hit_s & ex_mr_q);
      st_found_s = st_hit_s;
      for (int k = 0; k < NSTG; k++) begin
        st_hit_s   = p_valid_q[k] & p_rw_q[k] & (p_rd_q[k] == st_src_s);
        stall_s    = stall_s | (st_act_s & ~st_found_s & st_hit_s & p_mr_q[k] & ((k + 1) < LOAD_STG));
        st_found_s = st_found_s | st_hit_s;
      end
    end
  end

  // Forward select: one-hot on the youngest post-EX producer, stage k -> bit NSTG-1-k
  always_comb begin
    fwd_s      = '0;
    fw_act_s   = 1'b0;
    fw_hit_s   = 1'b0;
    fw_found_s = 1'b0;
    fw_src_s   = '0;
    for (int s = 0; s < NSRC; s++) begin
      fw_src_s   = ex_src_q[s*RW +: RW];
      fw_act_s   = ex_valid_q & ex_used_q[s] & (fw_src_s != '0);
      fw_found_s = 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        fw_hit_s = p_valid_q[k] & p_rw_q[k] & (p_rd_q[k] == fw_src_s);
        fwd_s[s*NSTG + (NSTG - 1 - k)] = fw_act_s & ~fw_found_s & fw_hit_s;
        fw_found_s = fw_found_s | fw_hit_s;
      end
    end
  end

  // Stall counter next state: clear wins, then saturating increment
  always_comb begin
    if (hz.cnt_clr) begin
      cnt_d = '0;
    end else if (stall_s && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline shadow: post-EX stages always advance; EX takes ID or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_rd_q    <= '0;
      ex_src_q   <= '0;
      ex_used_q  <= '0;
      p_valid_q  <= '0;
      p_rw_q     <= '0;
      p_mr_q     <= '0;
      for (int k = 0; k < NSTG; k++) begin
        p_rd_q[k] <= '0;
      end
      cnt_q      <= '0;
    end else begin
      p_valid_q[0] <= ex_valid_q;
      p_rw_q[0]    <= ex_rw_q;
      p_mr_q[0]    <= ex_mr_q;
      p_rd_q[0]    <= ex_rd_q;
      for (int k = 1; k < NSTG; k++) begin
        p_valid_q[k] <= p_valid_q[k-1];
        p_rw_q[k]    <= p_rw_q[k-1];
        p_mr_q[k]    <= p_mr_q[k-1];
        p_rd_q[k]    <= p_rd_q[k-1];
      end
      ex_valid_q <= hz.id_valid & ~hz.flush & ~stall_s;
      ex_rw_q    <= hz.id_regwrite;
      ex_mr_q    <= hz.id_memread;
      ex_rd_q    <= hz.id_rd;
      ex_src_q   <= hz.id_src;
      ex_used_q  <= hz.id_src_used;
      cnt_q      <= cnt_d;
    end
  end

  assign hz.stall     = stall_s;
  assign hz.fwd_sel   = fwd_s;
  assign hz.stall_cnt = cnt_q;

endmodule
